// File: rtl/mux_scan_sampler_pkg.sv
// Shared types and constants for the 4:1 mux scan sampler: FSM encoding,
// channel codes and the mapping from the channel code to the mux select pins.
package mux_scan_sampler_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    localparam logic [1:0] CH_A = 2'b00;
    localparam logic [1:0] CH_B = 2'b01;
    localparam logic [1:0] CH_C = 2'b10;
    localparam logic [1:0] CH_D = 2'b11;

    function automatic logic sel_to_s2(input logic [1:0] sel);
        return sel[1];
    endfunction

    function automatic logic sel_to_s1(input logic [1:0] sel);
        return sel[0];
    endfunction

endpackage

// File: rtl/mux_scan_sampler_if.sv
// Control/data bundle between the board-side controller plus 4:1 mux and the
// scan sampler; the slave modport is the sampler's view.
interface mux_scan_sampler_if;
    logic       start;
    logic       continuous;
    logic       y;
    logic       s1;
    logic       s2;
    logic [3:0] sample;
    logic       valid;
    logic       busy;

    modport master (
        output start, continuous, y,
        input  s1, s2, sample, valid, busy
    );

    modport slave (
        input  start, continuous, y,
        output s1, s2, sample, valid, busy
    );
endinterface

// File: rtl/mux_scan_sampler_dwell_timer.sv
// Counts the cycles a channel is held; done pulses on the last cycle of a dwell
// and the counter folds back to zero on that same edge, so it never wraps.
module dwell_timer #(
    parameter int DWELL_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count and end-of-dwell detect.
    always_comb begin
        cnt_d = cnt_q;
        done  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                done  = 1'b1;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_sampler.sv
// Steps the 4:1 mux select through all channels, captures y at the end of each
// dwell and publishes the four bits as one word with a single-cycle valid.
module mux_scan_sampler
    import mux_scan_sampler_pkg::*;
#(
    parameter int DWELL_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic               clk,
    input  logic               reset,
    mux_scan_sampler_if.slave  bus
);

    state_e     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] shadow_q, shadow_d;
    logic [3:0] sample_q, sample_d;
    logic       valid_q, valid_d;
    logic       dwell_done;
    logic       timer_en;
    logic       timer_clear;

    // The timer idles at zero so a new scan always starts with a full dwell.
    assign timer_en    = (state_q == ST_SCAN);
    assign timer_clear = (state_q == ST_IDLE);

    dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES),
        .CNT_W       (CNT_W)
    ) u_dwell_timer (
        .clk  (clk),
        .reset(reset),
        .clear(timer_clear),
        .en   (timer_en),
        .done (dwell_done)
    );

    // State register plus select, shadow and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sel_q    <= CH_A;
            shadow_q <= 4'b0000;
            sample_q <= 4'b0000;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    // Next-state logic: leave SCAN only after the last channel without continuous.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_SCAN;
                else           state_d = ST_IDLE;
            end
            ST_SCAN: begin
                if (dwell_done && (sel_q == CH_D) && !bus.continuous) state_d = ST_IDLE;
                else                                                  state_d = ST_SCAN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: the last capture bypasses the shadow so the word lands atomically.
    always_comb begin
        sel_d    = sel_q;
        shadow_d = shadow_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sel_d = CH_A;
            end
            ST_SCAN: begin
                if (dwell_done) begin
                    shadow_d[sel_q] = bus.y;
                    if (sel_q == CH_D) begin
                        sample_d = {bus.y, shadow_q[2:0]};
                        valid_d  = 1'b1;
                        sel_d    = CH_A;
                    end else begin
                        sel_d = sel_q + 2'b01;
                    end
                end else begin
                    sel_d = sel_q;
                end
            end
            default: begin
                sel_d = CH_A;
            end
        endcase
    end

    assign bus.s2     = sel_to_s2(sel_q);
    assign bus.s1     = sel_to_s1(sel_q);
    assign bus.sample = sample_q;
    assign bus.valid  = valid_q;
    assign bus.busy   = (state_q == ST_SCAN);

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Bench for mux_scan_sampler: two instances (dwell 1 and dwell 4) driving
// behavioural 4:1 muxes, checked by a table, directed sequences and a model.
module tb_mux_scan_sampler;

    logic       clk = 1'b0;
    logic       rst1 = 1'b1;
    logic       rst4 = 1'b1;
    logic [3:0] in1 = 4'b0000;
    logic [3:0] in4 = 4'b0000;
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;

    always #5 clk = ~clk;

    mux_scan_sampler_if if1 ();
    mux_scan_sampler_if if4 ();

    assign if1.y = in1[{if1.s2, if1.s1}];
    assign if4.y = in4[{if4.s2, if4.s1}];

    mux_scan_sampler #(.DWELL_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .reset(rst1), .bus(if1.slave)
    );
    mux_scan_sampler #(.DWELL_CYCLES(4), .CNT_W(8)) dut4 (
        .clk(clk), .reset(rst4), .bus(if4.slave)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: position within a scan, from which channel and capture points follow.
    int         md[2] = '{1, 4};
    bit         mb[2];
    int         mp[2];
    logic [3:0] mc[2];
    logic [3:0] ms[2];
    bit         mv[2];

    task automatic model_step(input int m, input logic r, input logic st, input logic ct,
                              input logic [3:0] inv);
        int ch;
        mv[m] = 1'b0;
        if (r) begin
            mb[m] = 1'b0; mp[m] = 0; mc[m] = 4'b0000; ms[m] = 4'b0000;
        end else if (!mb[m]) begin
            if (st) begin mb[m] = 1'b1; mp[m] = 0; end
        end else begin
            ch = mp[m] / md[m];
            if (mp[m] % md[m] == md[m] - 1) mc[m][ch] = inv[ch];
            if (mp[m] == 4 * md[m] - 1) begin
                ms[m] = mc[m]; mv[m] = 1'b1; mp[m] = 0; mb[m] = ct;
            end else begin
                mp[m]++;
            end
        end
    endtask

    task automatic model_cmp(input int m, input logic [1:0] sel, input logic [3:0] smp,
                             input logic v, input logic b);
        int esel;
        esel = mb[m] ? mp[m] / md[m] : 0;
        chk($sformatf("model%0d sel", m), 32'(sel), 32'(esel));
        chk($sformatf("model%0d sample", m), 32'(smp), 32'(ms[m]));
        chk($sformatf("model%0d valid", m), 32'(v), 32'(mv[m]));
        chk($sformatf("model%0d busy", m), 32'(b), 32'(mb[m]));
    endtask

    always @(posedge clk) begin
        model_step(0, rst1, if1.start, if1.continuous, in1);
        model_step(1, rst4, if4.start, if4.continuous, in4);
        cyc++;
        #1;
        model_cmp(0, {if1.s2, if1.s1}, if1.sample, if1.valid, if1.busy);
        model_cmp(1, {if4.s2, if4.s1}, if4.sample, if4.valid, if4.busy);
    end

    typedef struct {
        logic       rst, start, cont;
        logic [3:0] in;
        logic [1:0] sel;
        logic       valid;
        logic [3:0] sample;
        logic       busy;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic s, input logic c, input logic [3:0] i,
                                input logic [1:0] sl, input logic v, input logic [3:0] sm,
                                input logic b);
        vec_t t;
        t.rst = r; t.start = s; t.cont = c; t.in = i;
        t.sel = sl; t.valid = v; t.sample = sm; t.busy = b;
        return t;
    endfunction

    vec_t tbl[21];

    task automatic drive4(input logic r, input logic s, input logic c, input logic [3:0] i);
        @(negedge clk);
        rst4 = r; if4.start = s; if4.continuous = c; in4 = i;
    endtask

    task automatic post_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int k, nval, vat;
        bit seen;
        if1.start = 1'b0; if1.continuous = 1'b0;
        if4.start = 1'b0; if4.continuous = 1'b0;

        // Dwell-1 continuous scans with an input change mid-scan, then stop and reset.
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 4'b0110, 2'd0, 1'b0, 4'b0000, 1'b0);
        tbl[1]  = mk(1'b0, 1'b1, 1'b1, 4'b0110, 2'd0, 1'b0, 4'b0000, 1'b1);
        tbl[2]  = mk(1'b0, 1'b0, 1'b1, 4'b0110, 2'd1, 1'b0, 4'b0000, 1'b1);
        tbl[3]  = mk(1'b0, 1'b0, 1'b1, 4'b0110, 2'd2, 1'b0, 4'b0000, 1'b1);
        tbl[4]  = mk(1'b0, 1'b0, 1'b1, 4'b0110, 2'd3, 1'b0, 4'b0000, 1'b1);
        tbl[5]  = mk(1'b0, 1'b0, 1'b1, 4'b0110, 2'd0, 1'b1, 4'b0110, 1'b1);
        tbl[6]  = mk(1'b0, 1'b0, 1'b1, 4'b0110, 2'd1, 1'b0, 4'b0110, 1'b1);
        tbl[7]  = mk(1'b0, 1'b0, 1'b1, 4'b1111, 2'd2, 1'b0, 4'b0110, 1'b1);
        tbl[8]  = mk(1'b0, 1'b0, 1'b1, 4'b1111, 2'd3, 1'b0, 4'b0110, 1'b1);
        tbl[9]  = mk(1'b0, 1'b0, 1'b1, 4'b1111, 2'd0, 1'b1, 4'b1110, 1'b1);
        tbl[10] = mk(1'b0, 1'b0, 1'b1, 4'b1111, 2'd1, 1'b0, 4'b1110, 1'b1);
        tbl[11] = mk(1'b0, 1'b0, 1'b1, 4'b1111, 2'd2, 1'b0, 4'b1110, 1'b1);
        tbl[12] = mk(1'b0, 1'b0, 1'b1, 4'b1111, 2'd3, 1'b0, 4'b1110, 1'b1);
        tbl[13] = mk(1'b0, 1'b0, 1'b1, 4'b1111, 2'd0, 1'b1, 4'b1111, 1'b1);
        tbl[14] = mk(1'b0, 1'b0, 1'b0, 4'b1111, 2'd1, 1'b0, 4'b1111, 1'b1);
        tbl[15] = mk(1'b0, 1'b0, 1'b0, 4'b1111, 2'd2, 1'b0, 4'b1111, 1'b1);
        tbl[16] = mk(1'b0, 1'b0, 1'b0, 4'b1111, 2'd3, 1'b0, 4'b1111, 1'b1);
        tbl[17] = mk(1'b0, 1'b0, 1'b0, 4'b1111, 2'd0, 1'b1, 4'b1111, 1'b0);
        tbl[18] = mk(1'b0, 1'b0, 1'b0, 4'b1111, 2'd0, 1'b0, 4'b1111, 1'b0);
        tbl[19] = mk(1'b1, 1'b1, 1'b0, 4'b1111, 2'd0, 1'b0, 4'b0000, 1'b0);
        tbl[20] = mk(1'b0, 1'b0, 1'b0, 4'b1111, 2'd0, 1'b0, 4'b0000, 1'b0);

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            rst1 = tbl[i].rst; if1.start = tbl[i].start;
            if1.continuous = tbl[i].cont; in1 = tbl[i].in;
            post_edge();
            chk($sformatf("tbl[%0d] sel", i), 32'({if1.s2, if1.s1}), 32'(tbl[i].sel));
            chk($sformatf("tbl[%0d] valid", i), 32'(if1.valid), 32'(tbl[i].valid));
            chk($sformatf("tbl[%0d] sample", i), 32'(if1.sample), 32'(tbl[i].sample));
            chk($sformatf("tbl[%0d] busy", i), 32'(if1.busy), 32'(tbl[i].busy));
        end

        // Single dwell-4 scan, a=1 b=0 c=1 d=1.
        drive4(1'b1, 1'b0, 1'b0, 4'b1101);
        drive4(1'b0, 1'b1, 1'b0, 4'b1101);
        post_edge();
        chk("single start busy", 32'(if4.busy), 32'd1);
        chk("single start sel", 32'({if4.s2, if4.s1}), 32'd0);
        drive4(1'b0, 1'b0, 1'b0, 4'b1101);
        for (int j = 1; j <= 17; j++) begin
            if (j > 1) post_edge(); else begin @(posedge clk); #2; end
            if (j < 16) begin
                chk($sformatf("single sel@%0d", j), 32'({if4.s2, if4.s1}), 32'(j / 4));
                chk($sformatf("single hold@%0d", j), 32'(if4.sample), 32'h0);
            end else if (j == 16) begin
                chk("single valid", 32'(if4.valid), 32'd1);
                chk("single sample", 32'(if4.sample), 32'hd);
                chk("single end busy", 32'(if4.busy), 32'd0);
                chk("single end sel", 32'({if4.s2, if4.s1}), 32'd0);
            end else begin
                chk("single valid pulse", 32'(if4.valid), 32'd0);
            end
        end

        // start re-pulsed at scan cycles 3 and 7 must be ignored.
        drive4(1'b0, 1'b1, 1'b0, 4'b0010);
        post_edge();
        k = cyc; nval = 0; vat = -1;
        for (int j = 1; j <= 30; j++) begin
            drive4(1'b0, (j == 3 || j == 7), 1'b0, 4'b0010);
            post_edge();
            if (if4.valid) begin
                nval++; vat = cyc - k;
                chk("ignored sample", 32'(if4.sample), 32'h2);
            end
        end
        chk("ignored valid count", 32'(nval), 32'd1);
        chk("ignored valid time", 32'(vat), 32'd16);

        // continuous dropped at scan cycle 5: that scan completes, then idle.
        drive4(1'b0, 1'b1, 1'b1, 4'b1011);
        post_edge();
        k = cyc; nval = 0; vat = -1;
        for (int j = 1; j <= 40; j++) begin
            drive4(1'b0, 1'b0, (j < 6), 4'b1011);
            post_edge();
            if (if4.valid) begin
                nval++; vat = cyc - k;
                chk("contdrop sample", 32'(if4.sample), 32'hb);
            end
        end
        chk("contdrop valid count", 32'(nval), 32'd1);
        chk("contdrop valid time", 32'(vat), 32'd16);
        chk("contdrop busy", 32'(if4.busy), 32'd0);

        // Two-cycle reset mid-scan discards the partial scan and clears sample.
        drive4(1'b0, 1'b1, 1'b0, 4'b1111);
        for (int j = 0; j < 6; j++) drive4(1'b0, 1'b0, 1'b0, 4'b1111);
        drive4(1'b1, 1'b0, 1'b0, 4'b1111);
        drive4(1'b1, 1'b1, 1'b0, 4'b1111);
        drive4(1'b0, 1'b0, 1'b0, 4'b0100);
        chk("reset sample", 32'(if4.sample), 32'h0);
        chk("reset valid", 32'(if4.valid), 32'd0);
        chk("reset busy", 32'(if4.busy), 32'd0);
        chk("reset sel", 32'({if4.s2, if4.s1}), 32'd0);
        drive4(1'b0, 1'b1, 1'b0, 4'b0100);
        drive4(1'b0, 1'b0, 1'b0, 4'b0100);
        seen = 1'b0;
        for (int j = 0; j < 24 && !seen; j++) begin
            post_edge();
            if (if4.valid) begin
                seen = 1'b1;
                chk("post-reset sample", 32'(if4.sample), 32'h4);
            end
        end
        chk("post-reset valid seen", 32'(seen), 32'd1);

        // Randomized traffic on both instances, checked against the model every cycle.
        for (int j = 0; j < 3000; j++) begin
            @(negedge clk);
            rst1 = ($urandom_range(0, 149) == 0);
            rst4 = ($urandom_range(0, 199) == 0);
            if1.start = ($urandom_range(0, 3) == 0);
            if4.start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) if1.continuous = ~if1.continuous;
            else                            if1.continuous = if1.continuous;
            if ($urandom_range(0, 31) == 0) if4.continuous = ~if4.continuous;
            else                            if4.continuous = if4.continuous;
            in1 = 4'($urandom_range(0, 15));
            in4 = 4'($urandom_range(0, 15));
        end
        post_edge();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
